bus_trace: RTL
==============

BUS_TRACE -- requirements
Module: bus_trace

Interface
REQ-001 Parameter DEPTH, default 8, meaning record FIFO depth in entries; SHALL be a power of two, >= 2.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it low SHALL immediately clear all state.
REQ-004 sync  input  1  CPU SYNC; high marks the final (X3) clock of an 8-clock instruction cycle.
REQ-005 data  input  4  shared CPU/ROM/RAM 4-bit data bus, sampled every clock.
REQ-006 clear  input  1  synchronous clear of overflow, sync_err and cycle_count.
REQ-007 rec_valid  output  1  a fetch record is presented.
REQ-008 rec_ready  input  1  consumer accepts the record; transfer occurs when rec_valid and rec_ready are both high at a clock edge.
REQ-009 rec_addr  output  12  fetch address of the presented record.
REQ-010 rec_opcode  output  8  opcode of the presented record: OPR in [7:4], OPA in [3:0].
REQ-011 overflow  output  1  sticky; a record was dropped because the FIFO was full.
REQ-012 sync_err  output  1  sticky; sync arrived while phase was not X3.
REQ-013 cycle_count  output  32  count of completed instruction cycles since lock or clear.

Function
REQ-014 Phase counter SHALL be 3 bits: A1=0, A2, A3, M1, M2, X1, X2, X3=7.
REQ-015 Sync sampled high at an edge SHALL load phase A1 for the next clock; otherwise phase SHALL increment, wrapping X3->A1.
REQ-016 A locked flag SHALL clear on reset and set on the first sampled sync; before lock, no capture, count or push SHALL occur.
REQ-017 While locked, data SHALL be captured at A1->addr[3:0], A2->addr[7:4], A3->addr[11:8], M1->opcode[7:4], M2->opcode[3:0].
REQ-018 At the M2 edge the completed {addr, opcode} record SHALL be pushed; if the FIFO was empty, rec_valid SHALL be high from the following clock (X1), with no combinational bypass.
REQ-019 cycle_count SHALL increment by 1 at every locked M2 edge, including dropped records, and SHALL wrap 0xFFFFFFFF->0.
REQ-020 FIFO full at a push edge with no pop: record dropped, contents unchanged, overflow set.
REQ-021 FIFO full with a pop at the same edge as the push: both SHALL occur and the record SHALL NOT be dropped.
REQ-022 FIFO empty: rec_valid low; rec_addr and rec_opcode hold their last values (0 after reset).
REQ-023 Records SHALL leave in push order; rec_* SHALL remain stable while rec_valid is high and rec_ready is low.
REQ-024 Sync sampled while locked and phase is not X3: sync_err set, partial record discarded (no push for that cycle), phase resynchronised per REQ-015.
REQ-025 clear high at an edge: overflow, sync_err and cycle_count SHALL be zeroed; an increment at that same edge is lost; FIFO contents and lock are unaffected.

Reset
REQ-026 Reset low SHALL force phase=A1, locked=0, FIFO empty, rec_valid=0, rec_addr=0, rec_opcode=0, overflow=0, sync_err=0, cycle_count=0.
REQ-027 Reset asserted mid-cycle SHALL discard any partial record; after release, capture SHALL resume only after the next sync.

Structure
REQ-028 Shared package bus_trace_pkg SHALL hold the phase enum (A1..X3), the 20-bit record struct {addr[11:0], opcode[7:0]} and the ADDR_W=12 / OP_W=8 constants.
REQ-029 Buffering SHALL be a sub-module trace_fifo (parameter DEPTH, push/pop/full/empty, same clock and reset); phase tracking and capture SHALL live in bus_trace.

Verification
REQ-030 Sync, then bus nibbles 4,3,2,D,5 over A1..M2 -> one record addr=0x234, opcode=0xD5, rec_valid rises at X1, cycle_count=1.
REQ-031 rec_ready held low for 9 fetch cycles, DEPTH=8 -> 8 records retained in order, 9th dropped, overflow=1, cycle_count=9.
REQ-032 FIFO full, rec_ready high on the M2 edge of the next fetch -> oldest popped, new record accepted, overflow stays 0.
REQ-033 Sync pulse injected at phase M1 -> sync_err=1, that record not pushed, next full cycle yields a correct record.
REQ-034 Reset pulsed low at phase A3, then released -> all outputs 0, no record until the next sync plus a full cycle.
REQ-035 Data toggled with no sync ever asserted for 64 clocks -> rec_valid stays 0, cycle_count stays 0.

Source files
------------

// File: rtl/bus_trace_pkg.sv
// ============================================================================
// Module  : bus_trace_pkg
// Purpose : Shared phase encoding, fetch record layout and field widths.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bus_trace_pkg;

  localparam int ADDR_W = 12;
  localparam int OP_W   = 8;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   opcode;
  } rec_t;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module  : trace_fifo
// Purpose : Fetch record FIFO with a registered head; the head holds its last
//           value while empty.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module trace_fifo
  import bus_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  rec_t i_data,
  input  logic i_pop,
  output rec_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t          r_mem [DEPTH];
  rec_t          r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_rd_nxt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_rd_nxt  = r_rd_ptr + AW'(1);
  assign o_data    = r_head;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Head tracks the oldest entry; it is left untouched when draining to empty.
      if (w_do_pop) begin
        if (r_count > (AW+1)'(1)) r_head <= r_mem[w_rd_nxt];
        else if (w_do_push)       r_head <= i_data;
      end else if (o_empty && w_do_push) begin
        r_head <= i_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_trace.sv
// ============================================================================
// Module  : bus_trace
// Purpose : Tracks the 8-clock CPU instruction phase from SYNC and captures
//           {address, opcode} fetch records into a FIFO.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sync,
  input  logic [3:0]        i_data,
  input  logic              i_clear,
  output logic              o_rec_valid,
  input  logic              i_rec_ready,
  output logic [ADDR_W-1:0] o_rec_addr,
  output logic [OP_W-1:0]   o_rec_opcode,
  output logic              o_overflow,
  output logic              o_sync_err,
  output logic [31:0]       o_cycle_count
);

  phase_e            r_phase;
  phase_e            w_phase_nxt;
  logic              r_locked;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_op_hi;
  logic              r_overflow;
  logic              r_sync_err;
  logic [31:0]       r_cycle_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_sync_err;
  rec_t w_rec;
  rec_t w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= PH_A1;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = phase_e'(r_phase + 3'd1);
    if (i_sync) w_phase_nxt = PH_A1;
  end

  // A sync anywhere inside the cycle aborts it, so only an undisturbed M2 pushes.
  assign w_push     = r_locked && !i_sync && (r_phase == PH_M2);
  assign w_sync_err = r_locked && i_sync && (r_phase != PH_X3);
  assign w_rec      = {r_addr, r_op_hi, i_data};
  assign w_pop      = !w_empty && i_rec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_addr   <= '0;
      r_op_hi  <= '0;
    end else begin
      if (i_sync) r_locked <= 1'b1;
      if (r_locked && !i_sync) begin
        case (r_phase)
          PH_A1:   r_addr[3:0]  <= i_data;
          PH_A2:   r_addr[7:4]  <= i_data;
          PH_A3:   r_addr[11:8] <= i_data;
          PH_M1:   r_op_hi      <= i_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow    <= 1'b0;
      r_sync_err    <= 1'b0;
      r_cycle_count <= '0;
    end else if (i_clear) begin
      r_overflow    <= 1'b0;
      r_sync_err    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      if (w_push)                     r_cycle_count <= r_cycle_count + 32'd1;
      if (w_push && w_full && !w_pop) r_overflow    <= 1'b1;
      if (w_sync_err)                 r_sync_err    <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rec_valid   = !w_empty;
  assign o_rec_addr    = w_head.addr;
  assign o_rec_opcode  = w_head.opcode;
  assign o_overflow    = r_overflow;
  assign o_sync_err    = r_sync_err;
  assign o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire
